// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes one operand bit
// per clock, LSB first. Result, carry-out and signed overflow are registered.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_s;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    bit_s    = a_q[0] ^ b_q[0] ^ carry;
    c_next   = (a_q[0] & b_q[0]) | (a_q[0] & carry) | (b_q[0] & carry);
    res_next = {bit_s, res_q[WIDTH-1:1]};
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_next;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here.
            sum   <= res_next;
            cout  <= c_next;
            ovf   <= carry ^ c_next;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed 8-bit vectors plus an exhaustive 4-bit sweep,
// checked through per-instance expected queues popped on each done pulse.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic [1:0] st8;

  // 4-bit instance
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic [1:0] st4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .fsm_state(st8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .fsm_state(st4)
  );

  int n_vec = 0;
  int n_fail = 0;
  int n_done4 = 0;

  // Entry: {done cycle, cout, ovf, sum}
  localparam int QW8 = 32 + 2 + 8;
  localparam int QW4 = 32 + 2 + 4;
  logic [QW8-1:0] exp_q8[$];
  logic [QW4-1:0] exp_q4[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Independent reference: integer arithmetic and signed range test.
  function automatic logic [5:0] ref4(input int ia, input int ib, input int is);
    int t, sa, sb, r;
    logic [3:0] s;
    t  = (is != 0) ? (ia + 16 - ib) : (ia + ib);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    r  = (is != 0) ? (sa - sb) : (sa + sb);
    s  = t[3:0];
    return {logic'(t >= 16), logic'((r > 7) || (r < -8)), s};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp_q8.size() == 0) check("done8_unexpected", 64'd1, 64'd0);
      else check("result8", 64'({32'(cyc), cout8, ovf8, sum8}), 64'(exp_q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      n_done4++;
      if (exp_q4.size() == 0) check("done4_unexpected", 64'd1, 64'd0);
      else check("result4", 64'({32'(cyc), cout4, ovf4, sum4}), 64'(exp_q4.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input bit push);
    @(negedge clk);
    a8 = ta; b8 = tbv; sub8 = ts; start8 = 1'b1;
    @(posedge clk); #1;
    if (push) exp_q8.push_back({32'(cyc + 8), ec, eo, es});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                     input logic [7:0] es, input logic ec, input logic eo);
    issue8(ta, tbv, ts, es, ec, eo, 1'b1);
    repeat (9) @(posedge clk);
  endtask

  task automatic op4(input int ia, input int ib, input int is);
    logic [5:0] e;
    e = ref4(ia, ib, is);
    @(negedge clk);
    a4 = 4'(ia); b4 = 4'(ib); sub4 = logic'(is); start4 = 1'b1;
    @(posedge clk); #1;
    exp_q4.push_back({32'(cyc + 4), e});
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bc;
    int c0;
    repeat (3) @(posedge clk);
    #1;
    check("reset8", 64'({st8, busy8, done8, cout8, ovf8, sum8}), 64'd0);
    check("reset4", 64'({st4, busy4, done4, cout4, ovf4, sum4}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Carry propagation; busy for 8 cycles while sum holds the old result.
    issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 === 1'b1 && sum8 === 8'h00) bc++;
      @(negedge clk);
    end
    check("busy8_run_cycles", 64'(bc), 64'd8);
    check("busy8_in_done", 64'(busy8), 64'd0);
    @(posedge clk);

    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    op8(8'h3C, 8'hC3, 1'b1, 8'h79, 1'b0, 1'b0);

    // Operands and sub changed right after the start edge.
    issue8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    a8 = 8'h01; b8 = 8'hFF; sub8 = 1'b1;
    repeat (9) @(posedge clk);

    // start held high: one acceptance every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) exp_q8.push_back({32'(c0 + k * 10 + 8), 1'b0, 1'b1, 8'h80});
    repeat (20) @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (9) @(posedge clk);

    // Asynchronous reset after bit 2 has been processed (during bit 3).
    issue8(8'h55, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_midrun8", 64'({st8, busy8, done8, cout8, ovf8, sum8}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int is = 0; is < 2; is++)
          op4(ia, ib, is);

    repeat (5) @(posedge clk);
    check("q8_drained", 64'(exp_q8.size()), 64'd0);
    check("q4_drained", 64'(exp_q4.size()), 64'd0);
    check("done4_count", 64'(n_done4), 64'd512);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_vec++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A, unsigned or two's complement; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when a new result is valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result.
REQ-011 SHALL have port: cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-012 SHALL have port: ovf  output  1  signed overflow flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE + start=1 at edge E0 SHALL latch a, b, and sub; load B' = sub ? ~b : b; set carry flop = sub; set bit counter = 0; enter RUN.
REQ-015 IDLE + start=0 SHALL remain in IDLE.
REQ-016 RUN SHALL process one bit per edge, LSB first, through one full-adder cell: s = a_i ^ B'_i ^ c; c_next = majority(a_i, B'_i, c).
REQ-017 Each RUN edge SHALL shift s into an internal result shift register, update the carry flop, and increment the counter.
REQ-018 On edge EW, which processes bit WIDTH-1, the block SHALL enter DONE and load sum, cout, and ovf from the internal result.
REQ-019 Latency: done SHALL be high exactly in the cycle following edge EW, i.e. WIDTH edges after the start edge.
REQ-020 DONE SHALL last exactly one cycle, then the block SHALL enter IDLE unconditionally.
REQ-021 cout SHALL equal the carry out of bit WIDTH-1.
REQ-022 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 Result arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-024 busy SHALL be 1 iff state = RUN.
REQ-025 done SHALL be 1 iff state = DONE.
REQ-026 sum, cout, and ovf SHALL hold the previous result through IDLE and RUN, changing only at entry to DONE.
REQ-027 start asserted in RUN or DONE SHALL be ignored; it is not queued and has no effect on the operation in flight.
REQ-028 Changes on a, b, or sub after the start edge SHALL NOT affect the operation in flight.
REQ-029 Back-to-back throughput: next start SHALL be accepted at the first edge in IDLE, giving a minimum period of WIDTH+2 cycles.
REQ-030 Counter width SHALL be $clog2(WIDTH); the bit-(WIDTH-1) compare SHALL be exact for non-power-of-two WIDTH.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, and carry=0.
REQ-032 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-033 After reset_n rises, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Verification (WIDTH=8 unless stated)
REQ-034 Bench SHALL cover add with carry propagation: a=0x0F, b=0x01, sub=0 -> busy for 8 cycles; done pulse 8 edges after start; sum=0x10, cout=0, ovf=0.
REQ-035 Bench SHALL cover unsigned wrap and signed overflow: 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
REQ-036 Bench SHALL cover subtract: 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-037 Bench SHALL cover protocol: start held high through a whole operation -> exactly one done per WIDTH+2 cycles; operands changed mid-RUN -> result from originally latched values.
REQ-038 Bench SHALL cover reset mid-run: reset_n pulsed low at bit 3 -> outputs 0 asynchronously, no done; a fresh 0x12+0x34 then yields 0x46.
REQ-039 Bench SHALL cover exhaustive check at WIDTH=4: all a, b, and sub combinations (512) -> sum, cout, and ovf match a reference model; done count = 512.
